// File: rtl/state_squeezer.sv
// state_squeezer: SHAKE256 squeeze engine that streams captured Keccak rate lanes as 64-bit words.
module state_squeezer #(
  parameter int W = 64,
  parameter int RATE_LANES = 17,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        req_lanes,
  input  logic [0:4][0:4][0:63]   A,
  input  logic                    st_valid,
  output logic                    st_ready,
  output logic                    perm_req,
  output logic [W-1:0]            out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, WAIT_ST, STREAM} state_t;
  state_t state, nxt;
  logic [0:4][0:4][0:63] cap;
  logic [4:0] lane_idx;
  logic [CNT_W-1:0] remaining;
  logic [2:0] lx, ly;
  logic xfer, last, blk_end;
  assign st_ready  = state == WAIT_ST;
  assign out_valid = state == STREAM;
  assign busy      = state != IDLE;
  assign last      = remaining == CNT_W'(1);
  assign out_last  = out_valid && last;
  assign xfer      = out_valid && out_ready;
  assign blk_end   = lane_idx == 5'(RATE_LANES - 1);
  assign lx        = 3'(lane_idx % 5);
  assign ly        = 3'(lane_idx / 5);
  always_comb begin
    nxt = (state == IDLE && start && |req_lanes) ? WAIT_ST :
          (state == WAIT_ST && st_valid) ? STREAM :
          xfer ? (last ? IDLE : blk_end ? WAIT_ST : STREAM) : state;
  end
  // Lane words are stored z-ascending, so bit z of the word comes from A[x][y][z].
  always_comb begin
    out_data = '0;
    for (int z = 0; z < W; z++)
      out_data[z] = out_valid & cap[lx][ly][z];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cap       <= '0;
      lane_idx  <= '0;
      remaining <= '0;
      perm_req  <= 1'b0;
    end else begin
      state    <= nxt;
      perm_req <= xfer && !last && blk_end;
      if (state == IDLE && start && |req_lanes) remaining <= req_lanes;
      if (st_ready && st_valid) begin
        cap      <= A;
        lane_idx <= '0;
      end
      if (xfer) begin
        remaining <= remaining - CNT_W'(1);
        lane_idx  <= lane_idx + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_state_squeezer.sv
// tb_state_squeezer: scoreboard bench; a state source answers captures with per-block patterns.
module tb_state_squeezer;
  logic clk = 0, rst = 1, start = 0, st_valid = 1, out_ready = 1;
  logic [15:0] req_lanes = '0;
  logic [0:4][0:4][0:63] a_in;
  logic st_ready, perm_req, out_valid, out_last, busy;
  logic [63:0] out_data;
  int tests = 0, fails = 0, beats = 0, perm_cnt = 0, blk = 0, rdy_mode = 0, cyc = 0;
  logic [64:0] q[$];
  logic stall = 0;
  logic [64:0] held;

  state_squeezer dut (.clk(clk), .rst(rst), .start(start), .req_lanes(req_lanes), .A(a_in),
    .st_valid(st_valid), .st_ready(st_ready), .perm_req(perm_req), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [63:0] lane_val(int b, int i);
    return 64'hA5A5_0000_0000_0000 | 64'(b << 8) | 64'(i);
  endfunction

  always @* begin
    logic [63:0] v;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        v = lane_val(blk, 5 * y + x);
        for (int z = 0; z < 64; z++) a_in[x][y][z] = v[z];
      end
  end

  // Each capture advances the source to the next block, so A changes right after capture.
  always @(posedge clk or posedge rst)
    if (rst || !busy) blk <= 0;
    else if (st_valid && st_ready) blk <= blk + 1;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(1)) : (cyc % 4 == 0 || cyc % 4 == 3);
    st_valid  = rdy_mode == 1 ? 1'($urandom_range(1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (perm_req) perm_cnt++;
    if (rst) stall = 0;
    else begin
      if (!out_valid) chk("idle_data", {1'b0, out_data}, 65'd0);
      if (stall && out_valid) chk("stall_hold", {out_last, out_data}, held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("extra_beat", 65'd1, 65'd0);
        else chk("beat", {out_last, out_data}, q.pop_front());
        beats++;
      end
      stall = out_valid && !out_ready;
      held  = {out_last, out_data};
    end
  end

  task automatic pulse_start(input int n, input bit expect_run);
    @(negedge clk);
    if (expect_run) for (int k = 0; k < n; k++) q.push_back({k == n - 1, lane_val(k / 17, k % 17)});
    start = 1;
    req_lanes = 16'(n);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("timeout", 65'd1, 65'd0);
  endtask

  task automatic run(input string tag, input int n, input int perms);
    int p0 = perm_cnt;
    pulse_start(n, 1);
    wait_idle();
    @(negedge clk);
    chk({tag, "_drain"}, 65'(q.size()), 65'd0);
    chk({tag, "_perm"}, 65'(perm_cnt - p0), 65'(perms));
  endtask

  initial begin
    int n, p0;
    #1;
    chk("rst_out", {st_ready, perm_req, out_valid, out_last, busy, out_data}, '0);
    @(negedge clk);
    rst = 0;
    // single-lane request: one beat, busy drops the cycle after the transfer
    p0 = perm_cnt;
    pulse_start(1, 1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("one_valid", 65'(out_valid), 65'd1);
    @(negedge clk);
    chk("one_busy", 65'(busy), 65'd0);
    chk("one_drain", 65'(q.size()), 65'd0);
    chk("one_perm", 65'(perm_cnt - p0), 65'd0);
    run("r17", 17, 0);
    run("r20", 20, 1);
    run("r40", 40, 2);
    rdy_mode = 2;
    run("stall", 20, 1);
    rdy_mode = 1;
    run("rand", 37, 2);
    rdy_mode = 0;
    // zero-length request is ignored
    pulse_start(0, 0);
    chk("zero_busy", 65'(busy), 65'd0);
    @(negedge clk);
    chk("zero_busy2", 65'(busy), 65'd0);
    // second start during streaming must not alter the count
    p0 = perm_cnt;
    pulse_start(20, 1);
    repeat (4) @(negedge clk);
    start = 1;
    req_lanes = 16'd5;
    @(negedge clk);
    start = 0;
    wait_idle();
    @(negedge clk);
    chk("mid_drain", 65'(q.size()), 65'd0);
    chk("mid_perm", 65'(perm_cnt - p0), 65'd1);
    // asynchronous abort while beat 5 is presented
    beats = 0;
    p0 = perm_cnt;
    pulse_start(17, 1);
    n = 0;
    while (beats < 4 && n < 100) begin @(negedge clk); n++; end
    chk("abort_reach", 65'(beats), 65'd4);
    #1 rst = 1;
    #1 chk("abort_out", {st_ready, perm_req, out_valid, out_last, busy, out_data}, '0);
    q.delete();
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("abort_perm", 65'(perm_cnt - p0), 65'd0);
    chk("abort_idle", 65'(busy), 65'd0);
    run("after", 17, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
